// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, with a one-entry result stage.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); the default build is round-robin.
//
// state | meaning
// EMPTY | no result pending, any grant may issue
// FULL0 | result in rsp_data belongs to requester 0
// FULL1 | result in rsp_data belongs to requester 1
module alu_arbiter #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2:0]           req0_sel,
  input  logic [REG_WIDTH-1:0] req0_a,
  input  logic [REG_WIDTH-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2:0]           req1_sel,
  input  logic [REG_WIDTH-1:0] req1_a,
  input  logic [REG_WIDTH-1:0] req1_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [REG_WIDTH-1:0] rsp_data,
  output logic [2:0]           alu_sel,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  input  logic [REG_WIDTH-1:0] alu_res
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL0 = 2'd1,
    FULL1 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] rsp_data_q;
  logic                 drained;
  logic                 can_issue;
  logic                 grant_vld;
  logic                 grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                 rr_last_q;
`endif

  always_comb begin
    drained    = 1'b0;
    can_issue  = 1'b0;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_sel    = '0;
    alu_a      = '0;
    alu_b      = '0;

    drained = ((state_q == FULL0) && rsp0_ready) || ((state_q == FULL1) && rsp1_ready);
    // Nothing may be accepted while reset is held, even though state is already EMPTY.
    can_issue = rst_n && ((state_q == EMPTY) || drained);
    grant_vld = can_issue && (req0_valid || req1_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_id = !req0_valid;
`else
    grant_id = (req0_valid && req1_valid) ? !rr_last_q : req1_valid;
`endif

    if (grant_vld) begin
      if (grant_id) begin
        req1_ready = 1'b1;
        alu_sel    = req1_sel;
        alu_a      = req1_a;
        alu_b      = req1_b;
        state_d    = FULL1;
      end else begin
        req0_ready = 1'b1;
        alu_sel    = req0_sel;
        alu_a      = req0_a;
        alu_b      = req0_b;
        state_d    = FULL0;
      end
    end else if (drained) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_vld) rsp_data_q <= alu_res;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rr_last_q <= 1'b1;
    else if (grant_vld) rr_last_q <= grant_id;
  end
`endif

  assign rsp0_valid = (state_q == FULL0);
  assign rsp1_valid = (state_q == FULL1);
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* port.
// Build with +define+ALU_ARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_sel, req1_sel;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_a, alu_b, alu_res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.REG_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res)
  );

  // ALU encoding: ADD SUB AND OR XOR SLL SRL SRA
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      3'd0: alu_res = alu_a + alu_b;
      3'd1: alu_res = alu_a - alu_b;
      3'd2: alu_res = alu_a & alu_b;
      3'd3: alu_res = alu_a | alu_b;
      3'd4: alu_res = alu_a ^ alu_b;
      3'd5: alu_res = alu_a << alu_b[4:0];
      3'd6: alu_res = alu_a >> alu_b[4:0];
      default: alu_res = $signed(alu_a) >>> alu_b[4:0];
    endcase
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req0(input logic v, input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
  endtask

  task automatic drive_req1(input logic v, input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_req0(1'b0, 3'd0, '0, '0);
    drive_req1(1'b0, 3'd0, '0, '0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic exp_g0;
  logic prev_g0;

  initial begin
    rst_n = 1'b0;
    drive_req0(1'b1, 3'd0, 32'd1, 32'd1);
    drive_req1(1'b1, 3'd0, 32'd1, 32'd1);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    do_reset();

    // Single op: ADD 5+7
    drive_req0(1'b1, 3'd0, 32'd5, 32'd7);
    #1;
    chk("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("single_alu_a", alu_a, 32'd5);
    chk("single_alu_b", alu_b, 32'd7);
    @(negedge clk);
    drive_req0(1'b0, 3'd0, '0, '0);
    rsp0_ready = 1'b1;
    #1;
    chk("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("single_rsp_data", rsp_data, 32'd12);
    chk("idle_alu_a_zero", alu_a, 32'd0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk("single_drained", {31'd0, rsp0_valid}, 32'd0);
    chk("single_data_held", rsp_data, 32'd12);

    // Round-robin contention from a fresh reset: grants 0,1,0,1
    do_reset();
    drive_req0(1'b1, 3'd1, 32'd10, 32'd3);
    drive_req1(1'b1, 3'd4, 32'hF0, 32'h0F);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    prev_g0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_g0 = (i % 2 == 0);
      if (i > 0) begin
        chk("rr_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, prev_g0});
        chk("rr_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, !prev_g0});
        chk("rr_rsp_data", rsp_data, prev_g0 ? 32'd7 : 32'hFF);
      end
      chk("rr_req0_ready", {31'd0, req0_ready}, {31'd0, exp_g0});
      chk("rr_req1_ready", {31'd0, req1_ready}, {31'd0, !exp_g0});
      prev_g0 = exp_g0;
      @(negedge clk);
    end
    #1;
    chk("rr_last_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("rr_last_rsp_data", rsp_data, 32'hFF);

    // Drain, then backpressure on requester 1
    @(negedge clk);
    drive_req0(1'b0, 3'd0, '0, '0);
    drive_req1(1'b0, 3'd0, '0, '0);
    @(negedge clk);
    drive_req1(1'b1, 3'd5, 32'd1, 32'd4);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b0;
    #1;
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    drive_req1(1'b0, 3'd0, '0, '0);
    drive_req0(1'b1, 3'd0, 32'd2, 32'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("bp_rsp_data_held", rsp_data, 32'd16);
      chk("bp_req0_blocked", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp_release_req0_ready", {31'd0, req0_ready}, 32'd1);

    // Drain of FULL0 plus new issue from requester 1 in the same cycle
    @(negedge clk);
    drive_req0(1'b0, 3'd0, '0, '0);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    drive_req1(1'b1, 3'd7, 32'h8000_0000, 32'd4);
    #1;
    chk("di_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("di_rsp_data", rsp_data, 32'd5);
    chk("di_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    drive_req1(1'b0, 3'd0, '0, '0);
    rsp0_ready = 1'b0;
    #1;
    chk("di_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("di_rsp0_clear", {31'd0, rsp0_valid}, 32'd0);
    chk("di_sra_data", rsp_data, 32'hF800_0000);

    // Async reset with a result pending for requester 0
    @(negedge clk);
    rsp1_ready = 1'b1;
    drive_req0(1'b1, 3'd0, 32'd1, 32'd1);
    @(negedge clk);
    drive_req0(1'b0, 3'd0, '0, '0);
    rsp1_ready = 1'b0;
    #1;
    chk("ar_pre_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("ar_pre_rsp_data", rsp_data, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("ar_rsp_data", rsp_data, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive_req0(1'b1, 3'd0, 32'd4, 32'd4);
    drive_req1(1'b1, 3'd0, 32'd9, 32'd9);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("ar_first_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("ar_first_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("ar_first_rsp_data", rsp_data, 32'd8);

    // Continued contention: fixed priority keeps req0, round-robin alternates 1,0,1,0
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g0 = 1'b1;
`else
      exp_g0 = (i % 2 == 1);
`endif
      chk("cont_req0_ready", {31'd0, req0_ready}, {31'd0, exp_g0});
      chk("cont_req1_ready", {31'd0, req1_ready}, {31'd0, !exp_g0});
      @(negedge clk);
      #1;
      chk("cont_rsp_data", rsp_data, exp_g0 ? 32'd8 : 32'd18);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` instance between two requesters (execute-stage issue port = req0, address/CSR helper port = req1).
- Each requester presents an operation with a valid/ready handshake.
- Arbiter grants one per cycle, drives the ALU inputs, and registers the ALU output into a one-entry result stage.
- The result is returned on the granted requester's response channel with its own valid/ready handshake.

Parameters:
REG_WIDTH, `REG_WIDTH (32), operand/result width; must match the ALU instance.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_sel  input  3  requester 0 ALU select (ALU encoding 000 ADD to 111 SRA).
req0_a  input  REG_WIDTH  requester 0 operand A.
req0_b  input  REG_WIDTH  requester 0 operand B.
req1_valid, req1_ready, req1_sel, req1_a, req1_b: same as req0_*, for requester 1.
rsp0_valid  output  1  result pending for requester 0.
rsp0_ready  input  1  requester 0 accepts result.
rsp1_valid  output  1  result pending for requester 1.
rsp1_ready  input  1  requester 1 accepts result.
rsp_data  output  REG_WIDTH  registered result, shared by both response channels.
alu_sel  output  3  to ALU alu_sel.
alu_a  output  REG_WIDTH  to ALU dataA.
alu_b  output  REG_WIDTH  to ALU dataB.
alu_res  input  REG_WIDTH  from ALU alu_out.

Behaviour:
- Reset (rst_n low, async): rsp0_valid=0, rsp1_valid=0, rsp_data=0, result-owner=0, rr_last=1 (so req0 wins first contention). req*_ready=0 while in reset.
- Result stage states:
  - EMPTY: no rsp*_valid asserted.
  - FULL0: rsp0_valid=1.
  - FULL1: rsp1_valid=1.
  - rsp0_valid and rsp1_valid are never both 1.
- can_issue = EMPTY, or (FULL0 and rsp0_ready), or (FULL1 and rsp1_ready). Drain and new issue in the same cycle is allowed, giving full throughput of 1 op/cycle.
- Arbitration (combinational, when can_issue):
  - Only reqN_valid: grant N.
  - Both valid: grant the requester != rr_last.
  - Neither valid: no grant.
- reqN_ready = can_issue and grant==N. Handshake is reqN_valid & reqN_ready. Requester must hold sel/a/b stable while valid and not ready.
- ALU drive (combinational): alu_sel/alu_a/alu_b = granted requester's sel/a/b; all zeros when no grant.
- On grant, at the next rising edge:
  - rsp_data <= alu_res.
  - State <= FULLN.
  - rr_last <= N.
  - Latency: request accepted in cycle T, rspN_valid high in cycle T+1.
- Without grant: if current result drained this cycle, state <= EMPTY; rsp_data holds its last value.
- rspN_valid stays high with rsp_data stable until rspN_ready. The response is never dropped or overwritten.
- rr_last updates only on an actual grant, not on idle cycles.
- Arithmetic: rsp_data is the ALU result truncated to REG_WIDTH; the arbiter performs no arithmetic.
- Reset mid-operation: a pending result is discarded; after rst_n deasserts, the block starts in EMPTY with rr_last=1.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; req0 always wins contention and rr_last is unused (req1 can starve).
- Undefined (default): round-robin as described.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Single op: reset, then req0 ADD a=5 b=7 at cycle 1 -> req0_ready=1 cycle 1; rsp0_valid=1, rsp_data=12 cycle 2; rsp0_ready=1 -> rsp0_valid=0 cycle 3.
- Contention round-robin: both valid every cycle, rsp ready always 1; req0 SUB 10-3, req1 XOR 0xF0^0x0F -> grants alternate 0,1,0,1 starting with 0; rsp_data 7, 0xFF alternately, one per cycle.
- Backpressure: req1 SLL a=1 b=4 granted, rsp1_ready=0 for 3 cycles while req0 valid -> rsp_data=16 held, req0_ready=0 all 3 cycles; rsp1_ready=1 -> req0 granted that same cycle.
- Drain plus issue: FULL0 with rsp0_ready=1 and req1 SRA a=0x80000000 b=4 valid -> req1_ready=1 same cycle; next cycle rsp1_valid=1, rsp_data=0xF8000000 per ALU result.
- Async reset mid-op: rsp0_valid=1, pulse rst_n low between clock edges -> rsp0_valid=0 and rsp_data=0 immediately; after release, first contention grants req0.
- ALU_ARB_FIXED_PRIO_EN build: both valid for 4 cycles -> req0 granted all 4, req1_ready stays 0.
